// File: rtl/pb1_button_ctrl.sv
// pb1_button_ctrl: Avalon-MM push-button controller with debounce, press capture and maskable irq.
// Optional auto-repeat of held buttons is enabled by defining PB1_BTN_REPEAT_EN.
module pb1_button_ctrl #(
    parameter int WIDTH        = 3,
    parameter int TICK_DIV     = 50000,
    parameter int DEB_DEFAULT  = 20,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_TICKS = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [WIDTH-1:0] IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync1_q, sync2_q, p;
    logic [TW-1:0]    tick_q;
    logic             tick;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [7:0]       cnt_q [WIDTH];
    logic [7:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, edge_q, edge_d, rep_set;
    logic [7:0]       deb_q;
    logic [8:0]       thr;
    logic             wr, rep_en, irq_q;
    logic [31:0]      readdata_q, readdata_d;

    assign p    = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign tick = tick_q == TW'(TICK_DIV - 1);
    assign wr   = chipselect && !write_n;
    assign thr  = (deb_q == 8'd0) ? 9'd1 : {1'b0, deb_q};

    always_comb begin
        logic [8:0] inc;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            inc      = {1'b0, cnt_q[i]} + 9'd1;
            cnt_d[i] = cnt_q[i];
            if (p[i] == stable_q[i])
                cnt_d[i] = '0;
            else if (tick) begin
                // a threshold lowered mid-count still fires on the next tick
                if (inc >= thr) begin
                    stable_d[i] = ~stable_q[i];
                    cnt_d[i]    = '0;
                end else
                    cnt_d[i] = inc[7:0];
            end
        end
    end

`ifdef PB1_BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] rep_q [WIDTH];
    logic [RW-1:0] rep_d [WIDTH];
    logic          rep_en_q;

    assign rep_en = rep_en_q;

    always_comb begin
        rep_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rep_d[i] = rep_q[i];
            if (!stable_q[i] || !rep_en_q)
                rep_d[i] = '0;
            else if (tick) begin
                rep_set[i] = rep_q[i] == RW'(REPEAT_TICKS - 1);
                rep_d[i]   = rep_set[i] ? '0 : rep_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_en_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) rep_q[i] <= '0;
        end else begin
            rep_en_q <= (wr && address == 2'd3) ? writedata[31] : rep_en_q;
            for (int i = 0; i < WIDTH; i++) rep_q[i] <= rep_d[i];
        end
    end
`else
    assign rep_en  = 1'b0;
    assign rep_set = '0;
`endif

    // a press landing in the same cycle as a software clear is kept
    assign edge_d = (edge_q & ~((wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0))
                  | (stable_d & ~stable_q) | rep_set;

    assign readdata_d = (address == 2'd0) ? 32'(stable_q) :
                        (address == 2'd1) ? 32'(mask_q)   :
                        (address == 2'd2) ? 32'(edge_q)   :
                                            {rep_en, 23'd0, deb_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= IDLE;
            sync2_q    <= IDLE;
            tick_q     <= '0;
            stable_q   <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            deb_q      <= 8'(DEB_DEFAULT);
            irq_q      <= 1'b0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            tick_q     <= tick ? '0 : tick_q + 1'b1;
            stable_q   <= stable_d;
            mask_q     <= (wr && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
            edge_q     <= edge_d;
            deb_q      <= (wr && address == 2'd3) ? writedata[7:0] : deb_q;
            irq_q      <= |(edge_q & mask_q);
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule
